// File: rtl/light_sequencer.sv
// ============================================================================
// Module : light_sequencer
// Two-road intersection phase controller that programs and sequences an
// external phase timer. Optional run watchdog: define SEQ_WATCHDOG_EN.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module light_sequencer #(
  parameter int DW         = 32,
  parameter int WDOG_SLACK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [DW-1:0] green_time,
  input  logic [DW-1:0] yellow_time,
  input  logic [DW-1:0] red_time,
  input  logic          timer_done,
  output logic          timer_clr,
  output logic          timer_start,
  output logic [DW-1:0] timer_duration,
  output logic [2:0]    ns_light,
  output logic [2:0]    ew_light,
  output logic [2:0]    phase,
  output logic          busy,
  output logic          fault
);

  localparam logic [2:0] c_red    = 3'b100;
  localparam logic [2:0] c_yellow = 3'b010;
  localparam logic [2:0] c_green  = 3'b001;

  localparam logic [2:0] c_ph_ns_green  = 3'd0;
  localparam logic [2:0] c_ph_ns_yellow = 3'd1;
  localparam logic [2:0] c_ph_red_a     = 3'd2;
  localparam logic [2:0] c_ph_ew_green  = 3'd3;
  localparam logic [2:0] c_ph_ew_yellow = 3'd4;
  localparam logic [2:0] c_ph_red_b     = 3'd5;

  localparam logic [DW-1:0] c_dur_min = {{(DW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLR   = 2'd1,
    S_RUN   = 2'd2
`ifdef SEQ_WATCHDOG_EN
    , S_FAULT = 2'd3
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [2:0]    ns_q, ns_d;
  logic [2:0]    ew_q, ew_d;
  logic [DW-1:0] dur_q, dur_d;
  logic          clr_q, clr_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          fault_q, fault_d;

  logic          go_idle;
  logic          enter_clr;
  logic [2:0]    nxt_phase;
  logic [DW-1:0] raw_dur;

  function automatic logic [2:0] ns_of(input logic [2:0] ph);
    case (ph)
      c_ph_ns_green:  return c_green;
      c_ph_ns_yellow: return c_yellow;
      default:        return c_red;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(input logic [2:0] ph);
    case (ph)
      c_ph_ew_green:  return c_green;
      c_ph_ew_yellow: return c_yellow;
      default:        return c_red;
    endcase
  endfunction

`ifdef SEQ_WATCHDOG_EN
  localparam logic [DW+1:0] c_wd_extra = (DW+2)'(WDOG_SLACK + 1);
  localparam logic [DW:0]   c_wd_one   = {{DW{1'b0}}, 1'b1};

  logic [DW:0]   wd_q, wd_d;
  logic [DW+1:0] wd_limit;
  logic          wd_trip;

  // wd_q counts completed RUN cycles; +1 includes the current one.
  assign wd_limit = {2'b00, dur_q} + c_wd_extra;
  assign wd_trip  = ({1'b0, wd_q} + {1'b0, c_wd_one}) > wd_limit;

  always_comb begin
    wd_d = '0;
    if (state_q == S_RUN) begin
      wd_d = (&wd_q) ? wd_q : wd_q + c_wd_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  // Slack only matters with the watchdog; sink it to keep the parameter referenced.
  logic unused_slack;
  assign unused_slack = ^WDOG_SLACK;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dur_d     = dur_q;
    ns_d      = c_red;
    ew_d      = c_red;
    clr_d     = 1'b1;
    start_d   = 1'b0;
    fault_d   = 1'b0;
    go_idle   = 1'b0;
    enter_clr = 1'b0;
    nxt_phase = phase_q;
    raw_dur   = red_time;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          enter_clr = 1'b1;
          nxt_phase = c_ph_ns_green;
        end else begin
          go_idle = 1'b1;
        end
      end
      S_CLR: begin
        if (!enable || (phase_q > c_ph_red_b)) begin
          go_idle = 1'b1;
        end else begin
          state_d = S_RUN;
          clr_d   = 1'b0;
          start_d = 1'b1;
          ns_d    = ns_q;
          ew_d    = ew_q;
        end
      end
      S_RUN: begin
        if (!enable || (phase_q > c_ph_red_b)) begin
          go_idle = 1'b1;
        end else if (timer_done) begin
          enter_clr = 1'b1;
          nxt_phase = (phase_q == c_ph_red_b) ? c_ph_ns_green : phase_q + 3'd1;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_trip) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
        end
`endif
        else begin
          clr_d   = 1'b0;
          start_d = 1'b1;
          ns_d    = ns_q;
          ew_d    = ew_q;
        end
      end
`ifdef SEQ_WATCHDOG_EN
      S_FAULT: begin
        if (!enable) begin
          go_idle = 1'b1;
        end else begin
          fault_d = 1'b1;
        end
      end
`endif
      default: go_idle = 1'b1;
    endcase

    if (go_idle) begin
      state_d = S_IDLE;
      phase_d = c_ph_ns_green;
      dur_d   = '0;
    end

    case (nxt_phase)
      c_ph_ns_green, c_ph_ew_green:   raw_dur = green_time;
      c_ph_ns_yellow, c_ph_ew_yellow: raw_dur = yellow_time;
      default:                        raw_dur = red_time;
    endcase

    // A zero duration would never complete in the timer, so clamp it to 1.
    if (enter_clr) begin
      state_d = S_CLR;
      phase_d = nxt_phase;
      dur_d   = (raw_dur == '0) ? c_dur_min : raw_dur;
      ns_d    = ns_of(nxt_phase);
      ew_d    = ew_of(nxt_phase);
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= c_ph_ns_green;
      ns_q    <= c_red;
      ew_q    <= c_red;
      dur_q   <= '0;
      clr_q   <= 1'b1;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
      dur_q   <= dur_d;
      clr_q   <= clr_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  assign timer_clr      = clr_q;
  assign timer_start    = start_q;
  assign timer_duration = dur_q;
  assign ns_light       = ns_q;
  assign ew_light       = ew_q;
  assign phase          = phase_q;
  assign busy           = busy_q;
  assign fault          = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_light_sequencer.sv
// ============================================================================
// Module : tb_light_sequencer
// Directed self-checking bench for light_sequencer with a behavioural timer.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_light_sequencer;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] green_time;
  logic [31:0] yellow_time;
  logic [31:0] red_time;
  logic        timer_done;
  logic        timer_clr;
  logic        timer_start;
  logic [31:0] timer_duration;
  logic [2:0]  ns_light;
  logic [2:0]  ew_light;
  logic [2:0]  phase;
  logic        busy;
  logic        fault;

  int checks = 0;
  int errors = 0;

  logic [31:0] tcnt;
  logic        stuck_lo;

  light_sequencer #(.DW(32), .WDOG_SLACK(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .green_time     (green_time),
    .yellow_time    (yellow_time),
    .red_time       (red_time),
    .timer_done     (timer_done),
    .timer_clr      (timer_clr),
    .timer_start    (timer_start),
    .timer_duration (timer_duration),
    .ns_light       (ns_light),
    .ew_light       (ew_light),
    .phase          (phase),
    .busy           (busy),
    .fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Phase timer: cleared by timer_clr, counts while started, done at count == duration.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)           tcnt <= '0;
    else if (timer_clr)   tcnt <= '0;
    else if (timer_start) tcnt <= tcnt + 32'd1;
  end
  assign timer_done = !stuck_lo && !timer_clr && (tcnt == timer_duration);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_phase"}, {29'd0, phase}, 32'd0);
    check({tag, "_ns"}, {29'd0, ns_light}, {29'd0, R});
    check({tag, "_ew"}, {29'd0, ew_light}, {29'd0, R});
    check({tag, "_clr"}, {31'd0, timer_clr}, 32'd1);
    check({tag, "_start"}, {31'd0, timer_start}, 32'd0);
    check({tag, "_dur"}, timer_duration, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_fault"}, {31'd0, fault}, 32'd0);
  endtask

  task automatic enter_checks(input logic [2:0] ph, input logic [2:0] ns_e,
                              input logic [2:0] ew_e, input logic [31:0] dur_e);
    check($sformatf("entry_phase%0d", ph), {29'd0, phase}, {29'd0, ph});
    check($sformatf("entry_ns%0d", ph), {29'd0, ns_light}, {29'd0, ns_e});
    check($sformatf("entry_ew%0d", ph), {29'd0, ew_light}, {29'd0, ew_e});
    check($sformatf("entry_dur%0d", ph), timer_duration, dur_e);
    check($sformatf("entry_clr%0d", ph), {31'd0, timer_clr}, 32'd1);
    check($sformatf("entry_start%0d", ph), {31'd0, timer_start}, 32'd0);
    check($sformatf("entry_busy%0d", ph), {31'd0, busy}, 32'd1);
  endtask

  // Called just after the edge that enters CLR; returns at the next phase's entry.
  task automatic run_phase(input logic [2:0] ph, input int len, input logic [2:0] ns_e,
                           input logic [2:0] ew_e, input logic [31:0] dur_e,
                           input int chg_at, input logic [31:0] chg_val);
    int n;
    enter_checks(ph, ns_e, ew_e, dur_e);
    n = 0;
    do begin
      if (n == chg_at) green_time = chg_val;
      @(posedge clk); #1;
      n++;
      check("both_roads_open", {31'd0, (ns_light != R) && (ew_light != R)}, 32'd0);
      if (n == 1) begin
        check($sformatf("run_start%0d", ph), {31'd0, timer_start}, 32'd1);
        check($sformatf("run_clr%0d", ph), {31'd0, timer_clr}, 32'd0);
      end
    end while (phase == ph && n < 100);
    check($sformatf("len_phase%0d", ph), n, len);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n       = 1'b0;
    enable      = 1'b0;
    stuck_lo    = 1'b0;
    green_time  = 32'd5;
    yellow_time = 32'd2;
    red_time    = 32'd1;

    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("idle");

    // Nominal cycle: 7/4/3/7/4/3
    enable = 1'b1;
    @(posedge clk); #1;
    run_phase(3'd0, 7, G, R, 32'd5, -1, 32'd0);
    run_phase(3'd1, 4, Y, R, 32'd2, -1, 32'd0);
    run_phase(3'd2, 3, R, R, 32'd1, -1, 32'd0);
    run_phase(3'd3, 7, R, G, 32'd5, -1, 32'd0);
    run_phase(3'd4, 4, R, Y, 32'd2, -1, 32'd0);
    run_phase(3'd5, 3, R, R, 32'd1, -1, 32'd0);

    // Wrapped to phase 0; green changed to 9 mid-RUN only affects EW_GREEN
    run_phase(3'd0, 7, G, R, 32'd5, 2, 32'd9);
    run_phase(3'd1, 4, Y, R, 32'd2, -1, 32'd0);
    run_phase(3'd2, 3, R, R, 32'd1, -1, 32'd0);
    run_phase(3'd3, 11, R, G, 32'd9, -1, 32'd0);
    run_phase(3'd4, 4, R, Y, 32'd2, -1, 32'd0);
    run_phase(3'd5, 3, R, R, 32'd1, -1, 32'd0);

    // Zero yellow clamps to 1
    yellow_time = 32'd0;
    run_phase(3'd0, 11, G, R, 32'd9, -1, 32'd0);
    run_phase(3'd1, 3, Y, R, 32'd1, -1, 32'd0);
    run_phase(3'd2, 3, R, R, 32'd1, -1, 32'd0);

    // Drop enable on the same edge as timer_done in EW_GREEN
    enter_checks(3'd3, R, G, 32'd9);
    n = 0;
    while (timer_done !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("drop_done_seen", {31'd0, timer_done}, 32'd1);
    check("drop_wait", n, 32'd10);
    enable = 1'b0;
    @(posedge clk); #1;
    reset_checks("drop");

    // Re-enable restarts from phase 0
    yellow_time = 32'd2;
    enable      = 1'b1;
    @(posedge clk); #1;
    enter_checks(3'd0, G, R, 32'd9);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_start", {31'd0, timer_start}, 32'd1);

    // Asynchronous reset mid-RUN
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks("async_rst");
    enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("post_rst");

    // Stuck timer_done
    green_time = 32'd5;
    stuck_lo   = 1'b1;
    enable     = 1'b1;
    @(posedge clk); #1;
    enter_checks(3'd0, G, R, 32'd5);
    repeat (11) @(posedge clk);
    #1;
    check("wd_pre_fault", {31'd0, fault}, 32'd0);
    check("wd_pre_start", {31'd0, timer_start}, 32'd1);
    @(posedge clk); #1;
`ifdef SEQ_WATCHDOG_EN
    check("wd_fault", {31'd0, fault}, 32'd1);
    check("wd_ns", {29'd0, ns_light}, {29'd0, R});
    check("wd_ew", {29'd0, ew_light}, {29'd0, R});
    check("wd_clr", {31'd0, timer_clr}, 32'd1);
    check("wd_start", {31'd0, timer_start}, 32'd0);
    check("wd_busy", {31'd0, busy}, 32'd1);
`else
    check("nowd_fault", {31'd0, fault}, 32'd0);
    check("nowd_ns", {29'd0, ns_light}, {29'd0, G});
    check("nowd_start", {31'd0, timer_start}, 32'd1);
`endif
    enable = 1'b0;
    @(posedge clk); #1;
    reset_checks("wd_exit");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/light_sequencer.md
Name: light_sequencer

Overview:
Phase controller that sits directly upstream of the phase timer. It cycles a two-road intersection through its light phases. For each phase it programs the timer's duration, clears and starts the timer, and advances to the next phase on the timer's done. It owns the light outputs; the timer only measures phase length.

Parameters:
DW, 32, width of duration ports and timer_duration (matches timer duration width)
WDOG_SLACK, 4, extra cycles tolerated beyond expected RUN length before fault (only with SEQ_WATCHDOG_EN)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  level; 1 = run sequence, 0 = return to IDLE (all red)
green_time  input  DW  green phase duration, sampled on entry to CLR
yellow_time  input  DW  yellow phase duration, sampled on entry to CLR
red_time  input  DW  all-red clearance duration, sampled on entry to CLR
timer_done  input  1  done from timer
timer_clr  output  1  to timer rst (OR'd with system reset at top level); active-high clear
timer_start  output  1  to timer start; level
timer_duration  output  DW  to timer duration
ns_light  output  3  one-hot {red,yellow,green}, north-south
ew_light  output  3  one-hot {red,yellow,green}, east-west
phase  output  3  current phase code
busy  output  1  1 when not IDLE
fault  output  1  watchdog fault (tied 0 without macro)

Behaviour:
- All outputs registered.
- Async reset (rst_n=0) values: state=IDLE, phase=0, timer_clr=1, timer_start=0, timer_duration=0, ns_light=ew_light=3'b100, busy=0, fault=0.
- Phase codes, in cyclic order:
  - 0 NS_GREEN: ns=G, ew=R
  - 1 NS_YELLOW: ns=Y, ew=R
  - 2 RED_A: both R, red_time
  - 3 EW_GREEN: ns=R, ew=G
  - 4 EW_YELLOW: ns=R, ew=Y
  - 5 RED_B: both R, red_time
  - After phase 5, wrap to phase 0.
- Green phases use green_time; yellow phases use yellow_time.
- Light outputs change on the same edge phase changes, i.e. on entry to CLR.
- Controller states: IDLE, CLR, RUN (plus FAULT with macro).
- IDLE:
  - timer_clr=1, timer_start=0, both lights red, phase=0.
  - enable=1 → CLR with phase 0.
- CLR (exactly 1 cycle):
  - timer_clr=1, timer_start=0.
  - timer_duration = sampled duration for the phase; a value of 0 is clamped to 1 (timer never completes on 0).
  - Always → RUN.
  - timer_done is ignored in this state.
- RUN:
  - timer_clr=0, timer_start=1, timer_duration held.
  - timer_done=1 → CLR with next phase.
- Phase length with duration D (after clamp): 1 CLR cycle + D+1 RUN cycles = D+2 cycles.
- Enable rise → ns_light green visible 1 cycle after the edge that samples enable=1.
- enable=0 in any non-IDLE state → IDLE on next edge. Takes priority over timer_done on the same edge.
- Duration inputs changing mid-phase do not affect the current phase.
- rst_n asserted mid-phase: immediate return to reset values; sequence restarts from phase 0 after enable.
- Unused state/phase encodings recover to IDLE.

Optional Feature:
Macro SEQ_WATCHDOG_EN.
- Defined:
  - A RUN-cycle counter (DW+1 bits, no wrap) clears on CLR.
  - If it exceeds timer_duration+1+WDOG_SLACK without timer_done, go to FAULT.
  - FAULT: both lights red, timer_clr=1, timer_start=0, fault=1, busy=1.
  - Exit FAULT only via rst_n or enable=0 → IDLE, which clears fault.
- Not defined: no counter, no FAULT state; fault tied 0.

Test Plan:
- Reset: rst_n=0 mid-RUN → same cycle, ns_light=ew_light=3'b100, timer_clr=1, busy=0; after release with enable=0, outputs stay at reset values.
- Nominal sequence: green=5, yellow=2, red=1, enable=1 with real timer attached → phase lengths 7/4/3/7/4/3 cycles; full cycle 28 cycles; phase wraps 5→0; never both roads non-red.
- Zero duration: yellow_time=0 → timer_duration=1 in yellow phases; yellow lasts 3 cycles; no hang.
- Enable drop: enable=0 on the same edge timer_done=1 in phase 3 → IDLE next cycle, both red, phase=0; re-enable → phase 0.
- Mid-phase change: green_time changed 5→9 during NS_GREEN RUN → current green still 7 cycles; next EW_GREEN is 11 cycles.
- Watchdog (SEQ_WATCHDOG_EN): timer_done stuck 0, green=5 → fault=1 after 11 RUN cycles; both red; enable=0 clears fault.
